// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU arbiter slice.
//   alu_op_e  ALU operation select (add, sub, and, xor)
//   CC_*      bit positions inside the {ZF,SF,OF} condition-code vector
//   CC_RESET  condition-code value after reset (ZF set)
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_XOR = 2'b11
   } alu_op_e;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned CC_W  = 3;
   localparam int unsigned CC_ZF = 2;
   localparam int unsigned CC_SF = 1;
   localparam int unsigned CC_OF = 0;

   localparam logic [CC_W-1:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu_core.sv
// alu_core: the shared 64-bit combinational ALU.
//   op_i   operation select (alu_op_e encoding)
//   a_i    signed operand a
//   b_i    signed operand b
//   res_o  wrapped two's-complement result
//   ovf_o  signed overflow; 0 for and/xor
module alu_core
   import alu_pkg::*;
(
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] res_o,
   output logic            ovf_o
);

   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;

   assign sum  = a_i + b_i;
   assign diff = a_i - b_i;

   always_comb begin
      res_o = '0;
      ovf_o = 1'b0;
      unique case (alu_op_e'(op_i))
         ALU_ADD: begin
            res_o = sum;
            // Same-sign operands producing an opposite-sign result.
            ovf_o = (a_i[XLEN-1] == b_i[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);
         end
         ALU_SUB: begin
            res_o = diff;
            // Opposite-sign operands where the result sign departs from a.
            ovf_o = (a_i[XLEN-1] != b_i[XLEN-1]) && (diff[XLEN-1] != a_i[XLEN-1]);
         end
         ALU_AND: res_o = a_i & b_i;
         ALU_XOR: res_o = a_i ^ b_i;
      endcase
   end

endmodule

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: combinational round-robin picker.
//   req_i  request vector
//   ptr_i  index with highest priority this cycle
//   gnt_o  one-hot grant (zero when no request)
//   idx_o  index of the granted request
//   any_o  a grant was made
module alu_rr_pick #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   logic found;

   // First pass scans ptr..NREQ-1, second pass wraps to 0..ptr-1 (indices at
   // or above ptr cannot win there, since the first pass would have taken them).
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_i[i] && (i >= 32'(ptr_i))) begin
            gnt_o[i] = 1'b1;
            idx_o    = IDW'(i);
            found    = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_i[i]) begin
            gnt_o[i] = 1'b1;
            idx_o    = IDW'(i);
            found    = 1'b1;
         end
      end
   end

   assign any_o = found;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 64-bit ALU among NREQ requesters,
// with a single registered result slot.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_op/req_a/req_b    per-requester packed op (2b) and operands (64b)
//   req_setcc             per-requester: update condition codes on transfer
//   rsp_valid/rsp_ready   result handshake
//   rsp_id/rsp_val/rsp_ovf  producing requester, result, signed overflow
//   cc_out                {ZF,SF,OF}; only when ALU_ARB_CC_EN is defined
// Build option: define ALU_ARB_CC_EN to add the condition-code register.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [XLEN*NREQ-1:0] req_a,
   input  logic [XLEN*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]      req_setcc,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [XLEN-1:0]      rsp_val,
   output logic                 rsp_ovf
`ifdef ALU_ARB_CC_EN
   ,
   output logic [CC_W-1:0]      cc_out
`endif
);

   logic            rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0] rsp_val_q, rsp_val_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic            rsp_ovf_q, rsp_ovf_d;
   logic [IDW-1:0]  ptr_q, ptr_d;

   logic            out_free;
   logic [NREQ-1:0] pick_req;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_any;

   logic [1:0]      sel_op;
   logic [XLEN-1:0] sel_a;
   logic [XLEN-1:0] sel_b;
   logic [XLEN-1:0] alu_res;
   logic            alu_ovf;

   // Slot is free when empty or being drained this cycle, which gives
   // back-to-back reload without a bubble.
   assign out_free = !rsp_valid_q || rsp_ready;
   assign pick_req = out_free ? req_valid : '0;

   alu_rr_pick #(
      .NREQ(NREQ),
      .IDW (IDW)
   ) u_pick (
      .req_i(pick_req),
      .ptr_i(ptr_q),
      .gnt_o(gnt),
      .idx_o(gnt_idx),
      .any_o(gnt_any)
   );

   assign req_ready = gnt;

   // AND-OR operand mux driven by the one-hot grant.
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_op = sel_op | req_op[2*i +: 2];
            sel_a  = sel_a  | req_a[XLEN*i +: XLEN];
            sel_b  = sel_b  | req_b[XLEN*i +: XLEN];
         end
      end
   end

   alu_core u_alu (
      .op_i (sel_op),
      .a_i  (sel_a),
      .b_i  (sel_b),
      .res_o(alu_res),
      .ovf_o(alu_ovf)
   );

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_val_d   = rsp_val_q;
      rsp_id_d    = rsp_id_q;
      rsp_ovf_d   = rsp_ovf_q;
      ptr_d       = ptr_q;
      if (out_free) begin
         rsp_valid_d = gnt_any;
      end
      if (gnt_any) begin
         rsp_val_d = alu_res;
         rsp_id_d  = gnt_idx;
         rsp_ovf_d = alu_ovf;
         ptr_d     = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_val_q   <= '0;
         rsp_id_q    <= '0;
         rsp_ovf_q   <= 1'b0;
         ptr_q       <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_val_q   <= rsp_val_d;
         rsp_id_q    <= rsp_id_d;
         rsp_ovf_q   <= rsp_ovf_d;
         ptr_q       <= ptr_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_val   = rsp_val_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_ovf   = rsp_ovf_q;

`ifdef ALU_ARB_CC_EN
   logic [CC_W-1:0] cc_q, cc_d;
   logic            sel_setcc;

   always_comb begin
      sel_setcc = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_setcc = sel_setcc | req_setcc[i];
         end
      end
   end

   always_comb begin
      cc_d = cc_q;
      if (gnt_any && sel_setcc) begin
         cc_d[CC_ZF] = (alu_res == '0);
         cc_d[CC_SF] = alu_res[XLEN-1];
         cc_d[CC_OF] = alu_ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_q <= CC_RESET;
      end else begin
         cc_q <= cc_d;
      end
   end

   assign cc_out = cc_q;
`else
   logic unused_setcc;
   assign unused_setcc = ^req_setcc;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter (NREQ=2). Stimulus pushes the
// expected response into a queue at grant time; a monitor pops and compares
// each response as it is consumed. Condition codes are checked only when
// ALU_ARB_CC_EN is defined.
module tb_alu_arbiter;

   localparam int unsigned NREQ = 2;
   localparam int unsigned IDW  = 1;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [63:0]    val;
      logic           ovf;
   } exp_t;

   logic                clk;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [2*NREQ-1:0]   req_op;
   logic [64*NREQ-1:0]  req_a;
   logic [64*NREQ-1:0]  req_b;
   logic [NREQ-1:0]     req_setcc;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [63:0]         rsp_val;
   logic                rsp_ovf;
`ifdef ALU_ARB_CC_EN
   logic [2:0]          cc_out;
`endif

   int   checks;
   int   errors;
   exp_t exp_q[$];
   exp_t mon_e;

   alu_arbiter #(
      .NREQ(NREQ),
      .IDW (IDW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op   (req_op),
      .req_a    (req_a),
      .req_b    (req_b),
      .req_setcc(req_setcc),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id   (rsp_id),
      .rsp_val  (rsp_val),
      .rsp_ovf  (rsp_ovf)
`ifdef ALU_ARB_CC_EN
      ,
      .cc_out   (cc_out)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_cc(input string name, input logic [2:0] exp);
`ifdef ALU_ARB_CC_EN
      chk(name, 64'(cc_out), 64'(exp));
`else
      if (exp === 3'bxxx) $display("unused %s", name);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic sc);
      req_op[2*i +: 2]   = op;
      req_a[64*i +: 64]  = a;
      req_b[64*i +: 64]  = b;
      req_setcc[i]       = sc;
      req_valid[i]       = 1'b1;
   endtask

   task automatic push(input int id, input logic [63:0] val, input logic ovf);
      exp_t e;
      e.id  = IDW'(id);
      e.val = val;
      e.ovf = ovf;
      exp_q.push_back(e);
   endtask

   // Monitor: a response transfers on the next rising edge when valid && ready.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got id %0d val %h, no response expected",
                     rsp_id, rsp_val);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
            chk("rsp_val", rsp_val, mon_e.val);
            chk("rsp_ovf", 64'(rsp_ovf), 64'(mon_e.ovf));
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      req_setcc = '0;
      rsp_ready = 1'b1;
      #1 rst_n  = 1'b0;
      #2;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_val", rsp_val, 64'd0);
      chk("reset_rsp_id", 64'(rsp_id), 64'd0);
      chk("reset_rsp_ovf", 64'(rsp_ovf), 64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk_cc("reset_cc", 3'b100);
      step();
      step();
      rst_n = 1'b1;

      // Single add on requester 0: grant this cycle, result next cycle.
      set_req(0, 2'b00, 64'd5, 64'd7, 1'b0);
      @(negedge clk);
      chk("add_grant", 64'(req_ready), 64'b01);
      push(0, 64'd12, 1'b0);
      step();
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("add_latency_valid", 64'(rsp_valid), 64'd1);
      step();

      // Sub with overflow on requester 1 (ptr now 1), updating CC.
      set_req(1, 2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
      @(negedge clk);
      chk("sub_grant", 64'(req_ready), 64'b10);
      push(1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
      step();
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk_cc("sub_cc", 3'b001);
      step();

      // Both requesters valid for 4 cycles: grants alternate 0,1,0,1.
      set_req(0, 2'b00, 64'd100, 64'd1, 1'b0);
      set_req(1, 2'b11, 64'hF0, 64'h0F, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k % 2 == 0) begin
            chk("rr_grant0", 64'(req_ready), 64'b01);
            push(0, 64'd101, 1'b0);
         end else begin
            chk("rr_grant1", 64'(req_ready), 64'b10);
            push(1, 64'hFF, 1'b0);
         end
         step();
      end
      req_valid = '0;
      @(negedge clk);
      step();

      // Backpressure: result held for 3 cycles, then same-cycle regrant.
      rsp_ready = 1'b0;
      set_req(0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      set_req(1, 2'b10, 64'hF0F0, 64'hFF00, 1'b0);
      @(negedge clk);
      chk("stall_first_grant", 64'(req_ready), 64'b01);
      push(0, 64'h8000_0000_0000_0000, 1'b1);
      step();
      req_valid[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_req_ready", 64'(req_ready), 64'b00);
         chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
         chk("stall_rsp_val", rsp_val, 64'h8000_0000_0000_0000);
         chk("stall_rsp_id", 64'(rsp_id), 64'd0);
         chk("stall_rsp_ovf", 64'(rsp_ovf), 64'd1);
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("regrant_same_cycle", 64'(req_ready), 64'b10);
      push(1, 64'hF000, 1'b0);
      step();
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("no_bubble_valid", 64'(rsp_valid), 64'd1);
      step();

      // CC: xor with setcc sets ZF; following and without setcc leaves it.
      set_req(0, 2'b11, 64'hFF, 64'hFF, 1'b1);
      @(negedge clk);
      chk("xor_grant", 64'(req_ready), 64'b01);
      push(0, 64'd0, 1'b0);
      step();
      req_valid[0] = 1'b0;
      set_req(1, 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      @(negedge clk);
      chk_cc("xor_cc", 3'b100);
      chk("and_grant", 64'(req_ready), 64'b10);
      push(1, 64'h8000_0000_0000_0000, 1'b0);
      step();
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk_cc("and_cc_unchanged", 3'b100);
      step();

      // Reset mid-stream with a pending result (ptr=1 before reset).
      rsp_ready = 1'b0;
      set_req(0, 2'b00, 64'd1, 64'd1, 1'b1);
      @(negedge clk);
      chk("pre_reset_grant", 64'(req_ready), 64'b01);
      step();
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("pre_reset_valid", 64'(rsp_valid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_valid", 64'(rsp_valid), 64'd0);
      chk("async_reset_val", rsp_val, 64'd0);
      chk_cc("async_reset_cc", 3'b100);
      step();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      set_req(0, 2'b00, 64'd2, 64'd3, 1'b0);
      set_req(1, 2'b00, 64'd4, 64'd5, 1'b0);
      @(negedge clk);
      chk("post_reset_grant0", 64'(req_ready), 64'b01);
      push(0, 64'd5, 1'b0);
      step();
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("post_reset_grant1", 64'(req_ready), 64'b10);
      push(1, 64'd9, 1'b0);
      step();
      req_valid[1] = 1'b0;
      @(negedge clk);
      step();
      step();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
